// File: rtl/fir_output_level_meter.sv
// fir_output_level_meter: windowed max/min/mean-|x|/clip-count statistics on the FIR output stream.
module fir_output_level_meter #(
  parameter int DATA_WIDTH = 32,
  parameter int WINDOW_LOG2 = 10,
  parameter logic [DATA_WIDTH-1:0] CLIP_LEVEL = DATA_WIDTH'(64'd1 << 30)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  input  logic                         sample_valid,
  input  logic signed [DATA_WIDTH-1:0] data_in,
  output logic                         busy,
  output logic                         done,
  output logic                         result_valid,
  output logic signed [DATA_WIDTH-1:0] max_out,
  output logic signed [DATA_WIDTH-1:0] min_out,
  output logic        [DATA_WIDTH-1:0] mean_abs_out,
  output logic        [WINDOW_LOG2:0]  clip_count
);
  typedef enum logic [1:0] {IDLE, ACCUM, FINISH} state_t;
  localparam logic signed [DATA_WIDTH-1:0] POS_MAX = {1'b0, {(DATA_WIDTH-1){1'b1}}};
  localparam logic signed [DATA_WIDTH-1:0] NEG_MAX = {1'b1, {(DATA_WIDTH-1){1'b0}}};
  state_t state, state_nxt;
  logic begin_win, accept, last;
  logic [DATA_WIDTH-1:0] mag;
  logic signed [DATA_WIDTH-1:0] run_max, run_min;
  logic [DATA_WIDTH+WINDOW_LOG2-1:0] abs_sum;
  logic [WINDOW_LOG2:0] clip_acc;
  logic [WINDOW_LOG2-1:0] cnt;
  assign busy = (state != IDLE);
  // Two's-complement negate in DATA_WIDTH unsigned bits keeps |most-negative| exact.
  always_comb begin
    begin_win = (state == IDLE) && start;
    accept = (state == ACCUM) && sample_valid;
    last = accept && (&cnt);
    mag = data_in[DATA_WIDTH-1] ? (~data_in + 1'b1) : data_in;
    state_nxt = begin_win ? ACCUM : last ? FINISH : (state == FINISH) ? IDLE : state;
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else state <= state_nxt;
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      run_max <= '0;
      run_min <= '0;
      abs_sum <= '0;
      clip_acc <= '0;
      cnt <= '0;
    end else if (begin_win) begin
      run_max <= NEG_MAX;
      run_min <= POS_MAX;
      abs_sum <= '0;
      clip_acc <= '0;
      cnt <= '0;
    end else if (accept) begin
      run_max <= (data_in > run_max) ? data_in : run_max;
      run_min <= (data_in < run_min) ? data_in : run_min;
      abs_sum <= abs_sum + (DATA_WIDTH+WINDOW_LOG2)'(mag);
      clip_acc <= clip_acc + (WINDOW_LOG2+1)'(mag >= CLIP_LEVEL);
      cnt <= cnt + 1'b1;
    end
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      done <= 1'b0;
      result_valid <= 1'b0;
      max_out <= '0;
      min_out <= '0;
      mean_abs_out <= '0;
      clip_count <= '0;
    end else begin
      done <= (state == FINISH);
      result_valid <= (state == FINISH) ? 1'b1 : begin_win ? 1'b0 : result_valid;
      if (state == FINISH) begin
        max_out <= run_max;
        min_out <= run_min;
        mean_abs_out <= abs_sum[DATA_WIDTH+WINDOW_LOG2-1:WINDOW_LOG2];
        clip_count <= clip_acc;
      end
    end
  end
endmodule

// File: tb/tb_fir_output_level_meter.sv
// tb_fir_output_level_meter: directed checks of the level meter with an 8-sample window.
module tb_fir_output_level_meter;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic start = 1'b0;
  logic sample_valid = 1'b0;
  logic signed [31:0] data_in = '0;
  logic busy, done, result_valid;
  logic signed [31:0] max_out, min_out;
  logic [31:0] mean_abs_out;
  logic [3:0] clip_count;
  int tests = 0;
  int fails = 0;

  fir_output_level_meter #(.DATA_WIDTH(32), .WINDOW_LOG2(3), .CLIP_LEVEL(32'h4000_0000)) dut (
    .clk(clk), .rst(rst), .start(start), .sample_valid(sample_valid), .data_in(data_in),
    .busy(busy), .done(done), .result_valid(result_valid), .max_out(max_out),
    .min_out(min_out), .mean_abs_out(mean_abs_out), .clip_count(clip_count)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic feed(input logic signed [31:0] v, input int gap);
    sample_valid = 1'b1;
    data_in = v;
    tick();
    sample_valid = 1'b0;
    repeat (gap) tick();
  endtask

  task automatic test_reset();
    repeat (2) tick();
    tests += 7;
    if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy got %0b want 0", busy); end
    if (done !== 1'b0) begin fails++; $display("FAIL reset_done got %0b want 0", done); end
    if (result_valid !== 1'b0) begin fails++; $display("FAIL reset_rv got %0b want 0", result_valid); end
    if (max_out !== 32'sd0) begin fails++; $display("FAIL reset_max got %0d want 0", max_out); end
    if (min_out !== 32'sd0) begin fails++; $display("FAIL reset_min got %0d want 0", min_out); end
    if (mean_abs_out !== 32'd0) begin fails++; $display("FAIL reset_mean got %0d want 0", mean_abs_out); end
    if (clip_count !== 4'd0) begin fails++; $display("FAIL reset_clip got %0d want 0", clip_count); end
    rst = 1'b1;
    tick();
  endtask

  task automatic test_constant();
    do_start();
    tests++;
    if (busy !== 1'b1) begin fails++; $display("FAIL const_busy_after_start got %0b want 1", busy); end
    for (int i = 0; i < 8; i++) feed(32'sd1000, 0);
    tests += 2;
    if (done !== 1'b0) begin fails++; $display("FAIL const_finish_done got %0b want 0", done); end
    if (busy !== 1'b1) begin fails++; $display("FAIL const_finish_busy got %0b want 1", busy); end
    tick();
    tests += 7;
    if (done !== 1'b1) begin fails++; $display("FAIL const_done got %0b want 1", done); end
    if (busy !== 1'b0) begin fails++; $display("FAIL const_busy got %0b want 0", busy); end
    if (result_valid !== 1'b1) begin fails++; $display("FAIL const_rv got %0b want 1", result_valid); end
    if (max_out !== 32'sd1000) begin fails++; $display("FAIL const_max got %0d want 1000", max_out); end
    if (min_out !== 32'sd1000) begin fails++; $display("FAIL const_min got %0d want 1000", min_out); end
    if (mean_abs_out !== 32'd1000) begin fails++; $display("FAIL const_mean got %0d want 1000", mean_abs_out); end
    if (clip_count !== 4'd0) begin fails++; $display("FAIL const_clip got %0d want 0", clip_count); end
    tick();
    tests += 2;
    if (done !== 1'b0) begin fails++; $display("FAIL const_done_width got %0b want 0", done); end
    if (result_valid !== 1'b1) begin fails++; $display("FAIL const_rv_hold got %0b want 1", result_valid); end
  endtask

  task automatic test_alternating();
    do_start();
    for (int i = 0; i < 8; i++) feed((i % 2 == 0) ? 32'sd5000 : -32'sd3000, 0);
    tick();
    tests += 5;
    if (done !== 1'b1) begin fails++; $display("FAIL alt_done got %0b want 1", done); end
    if (max_out !== 32'sd5000) begin fails++; $display("FAIL alt_max got %0d want 5000", max_out); end
    if (min_out !== -32'sd3000) begin fails++; $display("FAIL alt_min got %0d want -3000", min_out); end
    if (mean_abs_out !== 32'd4000) begin fails++; $display("FAIL alt_mean got %0d want 4000", mean_abs_out); end
    if (clip_count !== 4'd0) begin fails++; $display("FAIL alt_clip got %0d want 0", clip_count); end
    tick();
  endtask

  task automatic test_extremes();
    do_start();
    for (int i = 0; i < 8; i++) feed((i < 4) ? 32'sh8000_0000 : 32'sh7FFF_FFFF, 0);
    tick();
    tests += 5;
    if (done !== 1'b1) begin fails++; $display("FAIL ext_done got %0b want 1", done); end
    if (max_out !== 32'sh7FFF_FFFF) begin fails++; $display("FAIL ext_max got %0d want 2147483647", max_out); end
    if (min_out !== 32'sh8000_0000) begin fails++; $display("FAIL ext_min got %0d want -2147483648", min_out); end
    if (mean_abs_out !== 32'd2147483647) begin fails++; $display("FAIL ext_mean got %0d want 2147483647", mean_abs_out); end
    if (clip_count !== 4'd8) begin fails++; $display("FAIL ext_clip got %0d want 8", clip_count); end
    tick();
  endtask

  task automatic test_gaps_restart();
    start = 1'b1;
    sample_valid = 1'b1;
    data_in = 32'sd1000;
    tick();
    start = 1'b0;
    sample_valid = 1'b0;
    tick();
    for (int i = 0; i < 8; i++) begin
      feed(32'sd1000, 0);
      if (i < 7) begin
        start = (i == 3);
        tick();
        start = 1'b0;
        tick();
        tests++;
        if (busy !== 1'b1 || done !== 1'b0) begin
          fails++;
          $display("FAIL gap_early_end after %0d samples got busy=%0b done=%0b want busy=1 done=0", i + 1, busy, done);
        end
      end
    end
    tick();
    tests += 5;
    if (done !== 1'b1) begin fails++; $display("FAIL gap_done got %0b want 1", done); end
    if (max_out !== 32'sd1000) begin fails++; $display("FAIL gap_max got %0d want 1000", max_out); end
    if (min_out !== 32'sd1000) begin fails++; $display("FAIL gap_min got %0d want 1000", min_out); end
    if (mean_abs_out !== 32'd1000) begin fails++; $display("FAIL gap_mean got %0d want 1000", mean_abs_out); end
    if (clip_count !== 4'd0) begin fails++; $display("FAIL gap_clip got %0d want 0", clip_count); end
    tick();
  endtask

  task automatic test_reset_mid_window();
    do_start();
    for (int i = 0; i < 5; i++) feed(32'sd1234, 0);
    rst = 1'b0;
    #1;
    tests += 4;
    if (busy !== 1'b0) begin fails++; $display("FAIL rstmid_busy got %0b want 0", busy); end
    if (result_valid !== 1'b0) begin fails++; $display("FAIL rstmid_rv got %0b want 0", result_valid); end
    if (max_out !== 32'sd0) begin fails++; $display("FAIL rstmid_max got %0d want 0", max_out); end
    if (mean_abs_out !== 32'd0) begin fails++; $display("FAIL rstmid_mean got %0d want 0", mean_abs_out); end
    sample_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      tests++;
      if (done !== 1'b0) begin fails++; $display("FAIL rstmid_done_in_reset got %0b want 0", done); end
    end
    sample_valid = 1'b0;
    rst = 1'b1;
    tick();
    do_start();
    for (int i = 0; i < 8; i++) feed(-32'sd7, 0);
    tick();
    tests += 5;
    if (done !== 1'b1) begin fails++; $display("FAIL rstmid_done got %0b want 1", done); end
    if (max_out !== -32'sd7) begin fails++; $display("FAIL rstmid_max_after got %0d want -7", max_out); end
    if (min_out !== -32'sd7) begin fails++; $display("FAIL rstmid_min_after got %0d want -7", min_out); end
    if (mean_abs_out !== 32'd7) begin fails++; $display("FAIL rstmid_mean_after got %0d want 7", mean_abs_out); end
    if (clip_count !== 4'd0) begin fails++; $display("FAIL rstmid_clip_after got %0d want 0", clip_count); end
  endtask

  task automatic test_back_to_back();
    tick();
    do_start();
    for (int i = 0; i < 8; i++) feed(32'sd200, 0);
    tick();
    tests += 2;
    if (done !== 1'b1) begin fails++; $display("FAIL b2b_first_done got %0b want 1", done); end
    if (max_out !== 32'sd200) begin fails++; $display("FAIL b2b_first_max got %0d want 200", max_out); end
    do_start();
    tests += 4;
    if (result_valid !== 1'b0) begin fails++; $display("FAIL b2b_rv_drop got %0b want 0", result_valid); end
    if (busy !== 1'b1) begin fails++; $display("FAIL b2b_busy got %0b want 1", busy); end
    if (done !== 1'b0) begin fails++; $display("FAIL b2b_done_width got %0b want 0", done); end
    if (max_out !== 32'sd200) begin fails++; $display("FAIL b2b_hold_max got %0d want 200", max_out); end
    for (int i = 0; i < 8; i++) feed((i % 2 == 0) ? 32'sd300 : -32'sd50, 0);
    tests += 2;
    if (min_out !== 32'sd200) begin fails++; $display("FAIL b2b_hold_min got %0d want 200", min_out); end
    if (mean_abs_out !== 32'd200) begin fails++; $display("FAIL b2b_hold_mean got %0d want 200", mean_abs_out); end
    tick();
    tests += 6;
    if (done !== 1'b1) begin fails++; $display("FAIL b2b_second_done got %0b want 1", done); end
    if (result_valid !== 1'b1) begin fails++; $display("FAIL b2b_second_rv got %0b want 1", result_valid); end
    if (max_out !== 32'sd300) begin fails++; $display("FAIL b2b_second_max got %0d want 300", max_out); end
    if (min_out !== -32'sd50) begin fails++; $display("FAIL b2b_second_min got %0d want -50", min_out); end
    if (mean_abs_out !== 32'd175) begin fails++; $display("FAIL b2b_second_mean got %0d want 175", mean_abs_out); end
    if (clip_count !== 4'd0) begin fails++; $display("FAIL b2b_second_clip got %0d want 0", clip_count); end
  endtask

  initial begin
    test_reset();
    test_constant();
    test_alternating();
    test_extremes();
    test_gaps_restart();
    test_reset_mid_window();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
